// File: rtl/mux2x1_rtl2.sv
// Two-input selector with a combinational output plus a registered shadow copy
// and a saturating counter of select transitions for debug visibility.
module mux2x1_rtl2 #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 select,
  input  logic                 en,
  input  logic                 clr,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 sel_q,
  output logic [CNT_WIDTH-1:0] sel_changes,
  output logic                 cnt_sat
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     out_d;
  logic                 sel_d;
  logic                 sel_prev_q;
  logic                 sel_prev_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 sel_toggle;

  // Case form so an unknown select yields X rather than a silent default.
  always_comb begin
    case (select)
      1'b0:    out = in1;
      1'b1:    out = in2;
      default: out = 'x;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    sel_d      = sel_q;
    sel_prev_d = select;
    sel_toggle = (select != sel_prev_q);
    cnt_d      = cnt_q;
    if (en) begin
      out_d = out;
      sel_d = select;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (sel_toggle && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      sel_q      <= 1'b0;
      sel_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      sel_q      <= sel_d;
      sel_prev_q <= sel_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sel_changes = cnt_q;
  assign cnt_sat     = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_mux2x1_rtl2.sv
// Directed bench for mux2x1_rtl2: a 1-bit/8-bit-counter instance and an
// 8-bit/3-bit-counter instance share clock, reset and control.
module tb_mux2x1_rtl2;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n;
  logic       select, en, clr;
  logic       a_in1, a_in2;
  logic [7:0] b_in1, b_in2;

  logic       a_out, a_out_q, a_sel_q, a_sat;
  logic [7:0] a_cnt;
  logic [7:0] b_out, b_out_q;
  logic       b_sel_q, b_sat;
  logic [2:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;

  mux2x1_rtl2 #(.WIDTH(1), .CNT_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in1(a_in1), .in2(a_in2), .select(select),
    .en(en), .clr(clr), .out(a_out), .out_q(a_out_q), .sel_q(a_sel_q),
    .sel_changes(a_cnt), .cnt_sat(a_sat));

  mux2x1_rtl2 #(.WIDTH(8), .CNT_WIDTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in1(b_in1), .in2(b_in2), .select(select),
    .en(en), .clr(clr), .out(b_out), .out_q(b_out_q), .sel_q(b_sel_q),
    .sel_changes(b_cnt), .cnt_sat(b_sat));

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic sel;
    logic in2;
    logic in1;
    logic exp_out;
  } tt_vec_t;

  tt_vec_t tt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tt[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[5] = '{1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; en = 1'b1; clr = 1'b0; select = 1'b0;
    a_in1 = 1'b0; a_in2 = 1'b0; b_in1 = 8'hA5; b_in2 = 8'h3C;
    #1;
    chk("reset_out_q", {31'd0, a_out_q}, 32'd0);
    chk("reset_sel_q", {31'd0, a_sel_q}, 32'd0);
    chk("reset_cnt", {24'd0, a_cnt}, 32'd0);
    chk("reset_sat", {31'd0, a_sat}, 32'd0);

    // Combinational truth table with clock idle and reset held.
    for (int i = 0; i < 6; i++) begin
      select = tt[i].sel; a_in2 = tt[i].in2; a_in1 = tt[i].in1;
      #14;
      chk($sformatf("tt_out[%0d]", i), {31'd0, a_out}, {31'd0, tt[i].exp_out});
      #1;
    end

    // Registered path.
    select = 1'b0; a_in1 = 1'b1; a_in2 = 1'b0; en = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    edge_sample();
    chk("reg_out_q_sel0", {31'd0, a_out_q}, 32'd1);
    chk("reg_sel_q_sel0", {31'd0, a_sel_q}, 32'd0);
    chk("reg_cnt_first", {24'd0, a_cnt}, 32'd0);
    chk("w8_out_sel0", {24'd0, b_out}, 32'hA5);
    chk("w8_out_q_sel0", {24'd0, b_out_q}, 32'hA5);

    @(negedge clk);
    select = 1'b1;
    #1;
    chk("w8_out_sel1", {24'd0, b_out}, 32'h3C);
    chk("w8_out_q_not_yet", {24'd0, b_out_q}, 32'hA5);
    edge_sample();
    chk("reg_out_q_sel1", {31'd0, a_out_q}, 32'd0);
    chk("reg_sel_q_sel1", {31'd0, a_sel_q}, 32'd1);
    chk("cnt_after_first_toggle", {24'd0, a_cnt}, 32'd1);
    chk("w8_out_q_sel1", {24'd0, b_out_q}, 32'h3C);

    // Hold with en low; counter still sees the 1->0 transition.
    @(negedge clk);
    en = 1'b0; select = 1'b0; a_in1 = 1'b1; a_in2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      chk($sformatf("hold_out_q[%0d]", i), {31'd0, a_out_q}, 32'd0);
      chk($sformatf("hold_sel_q[%0d]", i), {31'd0, a_sel_q}, 32'd1);
      chk($sformatf("hold_cnt[%0d]", i), {24'd0, a_cnt}, 32'd2);
    end

    @(negedge clk);
    clr = 1'b1; en = 1'b1;
    edge_sample();
    chk("clr_idle", {24'd0, a_cnt}, 32'd0);
    @(negedge clk);
    clr = 1'b0; a_in1 = 1'b0; a_in2 = 1'b1;

    // Five consecutive toggles.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      select = ~select;
      edge_sample();
      chk($sformatf("toggle_cnt[%0d]", i), {24'd0, a_cnt}, i);
      chk($sformatf("toggle_out_q[%0d]", i), {31'd0, a_out_q}, {31'd0, select});
    end
    for (int i = 0; i < 4; i++) begin
      edge_sample();
      chk($sformatf("steady_cnt[%0d]", i), {24'd0, a_cnt}, 32'd5);
    end

    // Clear wins over a simultaneous transition; sel_q still captures.
    @(negedge clk);
    select = ~select; clr = 1'b1;
    edge_sample();
    chk("clr_on_toggle", {24'd0, a_cnt}, 32'd0);
    chk("clr_sel_q_unaffected", {31'd0, a_sel_q}, {31'd0, select});
    @(negedge clk);
    clr = 1'b0;
    edge_sample();
    chk("after_clr_no_toggle", {24'd0, a_cnt}, 32'd0);

    // Saturation on the 3-bit counter instance.
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      select = ~select;
      edge_sample();
      chk($sformatf("sat_cnt[%0d]", i), {29'd0, b_cnt}, (i < 7) ? i : 7);
      chk($sformatf("sat_flag[%0d]", i), {31'd0, b_sat}, (i >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("wide_cnt[%0d]", i), {24'd0, a_cnt}, i);
    end
    chk("wide_sat_flag", {31'd0, a_sat}, 32'd0);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_q", {31'd0, a_out_q}, 32'd0);
    chk("arst_sel_q", {31'd0, a_sel_q}, 32'd0);
    chk("arst_cnt", {24'd0, b_cnt}, 32'd0);
    chk("arst_sat", {31'd0, b_sat}, 32'd0);
    chk("arst_w8_out_q", {24'd0, b_out_q}, 32'd0);
    select = 1'b1; a_in1 = 1'b0; a_in2 = 1'b1;
    #1;
    chk("arst_out_tracks1", {31'd0, a_out}, 32'd1);
    chk("arst_w8_out_tracks1", {24'd0, b_out}, 32'h3C);
    select = 1'b0;
    #1;
    chk("arst_out_tracks0", {31'd0, a_out}, 32'd0);
    chk("arst_w8_out_tracks0", {24'd0, b_out}, 32'hA5);
    edge_sample();
    chk("arst_held_cnt", {24'd0, a_cnt}, 32'd0);

    clk_run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux2x1_rtl2.md
Name: mux2x1_rtl2

Overview:
- Two-input selector: steers `in1` or `in2` to `out` under control of `select`.
- Primary output `out` is purely combinational and is the contractual datapath.
- A clocked shadow section provides:
  - a registered copy of the mux result;
  - a registered copy of `select`;
  - a saturating count of `select` transitions, for debug/observability in the surrounding datapath.

Parameters:
- WIDTH, 1, bit width of `in1`, `in2`, `out`, `out_q`.
- CNT_WIDTH, 8, bit width of the select-transition counter `sel_changes`.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in1  input  WIDTH  data input routed when `select`=0.
- in2  input  WIDTH  data input routed when `select`=1.
- select  input  1  route control: 0 selects `in1`, 1 selects `in2`.
- en  input  1  capture enable for `out_q`/`sel_q`; the counter ignores it.
- clr  input  1  synchronous clear of `sel_changes` only.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.
- sel_q  output  1  registered `select`.
- sel_changes  output  CNT_WIDTH  saturating count of `select` transitions.
- cnt_sat  output  1  high when `sel_changes` equals all-ones.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Combinational path:
  - `out` = `select` ? `in2` : `in1`.
  - Zero latency; independent of `clk`, `rst_n`, `en`, `clr`.
  - `out` is valid during reset.
- If `select` is X/Z, `out` is driven to X (no priority default). Simulation only; not a synthesis concern.
- Reset (`rst_n`=0, asynchronous assert, synchronous-to-`clk` deassert by the system): `out_q`=0, `sel_q`=0, `sel_changes`=0, `cnt_sat`=0, internal previous-select register=0.
- Registered path, each rising `clk` with `rst_n`=1:
  - if `en`=1: `out_q` <= (`select` ? `in2` : `in1`), `sel_q` <= `select`;
  - if `en`=0: both hold.
  - Latency is 1 cycle from input to `out_q`.
- Transition counter:
  - An internal register `sel_prev` samples `select` every cycle, regardless of `en`.
  - A transition is `select` != `sel_prev` at the clock edge.
  - On a transition, `sel_changes` increments by 1 unless already all-ones; it saturates and does not wrap.
  - `cnt_sat` = (`sel_changes` == 2^CNT_WIDTH-1), combinational from the register.
  - The first cycle after reset compares against `sel_prev`=0, so `select`=1 at the first edge counts as one transition.
- Simultaneous events:
  - `clr`=1 with a transition in the same cycle gives `sel_changes` <= 0; clear wins.
  - `clr` does not affect `out_q`, `sel_q`, or `sel_prev`.
- Reset mid-operation: all registered outputs return immediately (asynchronously) to their reset values; `out` keeps following its inputs.
- No handshake; inputs are sampled every cycle.

Test Plan:
- Combinational truth table, WIDTH=1, with `clk` idle and `rst_n`=0: drive {`select`,`in2`,`in1`} = 001, 010, 011, 101, 110, 111, holding each 15 ns. Required `out` = 1, 0, 1, 0, 1, 1 respectively.
- Registered path:
  - Release reset with `en`=1, `select`=0, `in1`=1, `in2`=0: `out_q`=1 after 1 edge and `sel_q`=0.
  - Set `select`=1: `out_q`=0 and `sel_q`=1 after the next edge.
  - Drop `en`: change inputs; `out_q`/`sel_q` hold for 3 edges.
- Counter:
  - Toggle `select` on 5 consecutive cycles: `sel_changes`=5.
  - Hold `select` steady for 4 cycles: the count stays at 5.
  - Assert `clr` on a toggle cycle: the count becomes 0.
- Saturation with CNT_WIDTH=3: toggle `select` 10 times. `sel_changes` sticks at 7, `cnt_sat`=1 from the 7th transition on, and the count never wraps to 0.
- Async reset mid-run:
  - Pull `rst_n` low between clock edges: `out_q`, `sel_q`, `sel_changes`, and `cnt_sat` all become 0 without waiting for an edge.
  - `out` continues tracking `select` ? `in2` : `in1`.
- WIDTH=8: `in1`=0xA5, `in2`=0x3C. `out` = 0xA5 with `select`=0 and 0x3C with `select`=1, and `out_q` matches one cycle later.
